// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Purpose:
//   Sits between the execute-stage resolution logic and the fetch-stage PC mux.
//   It chooses one redirect request by priority (trap > branch > jump). A
//   redirect that arrives while fetch is stalled is held until fetch can
//   accept it. Flush is held high for FLUSH_CYCLES cycles, counting the issue
//   cycle, so that every wrong-path stage is killed. The module also counts
//   issued redirects in a saturating counter.
//
// Parameters:
//   XLEN         - PC / target width in bits
//   FLUSH_CYCLES - cycles flush stays high per redirect, counting the issue
//                  cycle (1..15)
//   CNT_W        - width of the saturating redirect counter
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   branch          - conditional branch resolved taken; branch_target = its PC
//   jal_en, jalr_en - jump in execute; jump_target = its PC
//   trap_en         - trap request; trap_vector = handler PC
//   fetch_stall     - fetch cannot load a new PC this cycle
//   pc_mux_ctrl     - 00 PC+4, 01 branch, 10 jump, 11 trap
//   redirect_pc     - selected target, zero when pc_mux_ctrl = 00
//   flush           - kill younger pipeline stages
//   busy            - high while a redirect is pending or flushing
//   redirect_count  - number of issued redirects, saturating
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jal_en,
  input  logic             jalr_en,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             trap_en,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             fetch_stall,
  output logic [1:0]       pc_mux_ctrl,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_count
);

  // The flush counter only has to hold FLUSH_CYCLES-1, and the legal maximum
  // of that is 14.
  localparam int FCNT_W = 4;
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam bit  HAS_FLUSH_TAIL = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    SEL_PC4    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_TRAP   = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PENDING  = 2'b01,
    ST_FLUSHING = 2'b10
  } state_e;

  state_e             state_q,  state_d;
  sel_e               kind_q,   kind_d;
  logic [XLEN-1:0]    target_q, target_d;
  logic [FCNT_W-1:0]  cnt_q,    cnt_d;
  logic [CNT_W-1:0]   count_q;

  // Selected request, before the state machine decides what to do with it.
  logic               req_valid;
  sel_e               req_kind;
  logic [XLEN-1:0]    req_target;

  // A request that the FSM accepts this cycle. Outside IDLE, only a trap can
  // start a new redirect. Branches and jumps seen there are on the wrong path.
  logic               new_valid;
  sel_e               new_kind;
  logic [XLEN-1:0]    new_target;

  // Raw combinational outputs, before the reset override.
  sel_e               sel_c;
  logic [XLEN-1:0]    pc_c;
  logic               flush_c;

  // -------------------------------------------------------------------------
  // Priority decode: trap > branch > jump. If branch and jal_en are both
  // high (an illegal case), branch wins with no error.
  // -------------------------------------------------------------------------
  always_comb begin
    req_valid  = 1'b0;
    req_kind   = SEL_PC4;
    req_target = '0;
    if (trap_en) begin
      req_valid  = 1'b1;
      req_kind   = SEL_TRAP;
      req_target = trap_vector;
    end else if (branch) begin
      req_valid  = 1'b1;
      req_kind   = SEL_BRANCH;
      req_target = branch_target;
    end else if (jal_en || jalr_en) begin
      req_valid  = 1'b1;
      req_kind   = SEL_JUMP;
      req_target = jump_target;
    end
  end

  always_comb begin
    if (state_q == ST_IDLE) begin
      new_valid  = req_valid;
      new_kind   = req_kind;
      new_target = req_target;
    end else begin
      new_valid  = trap_en;
      new_kind   = SEL_TRAP;
      new_target = trap_vector;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    sel_c    = SEL_PC4;
    pc_c     = '0;
    flush_c  = 1'b0;

    if (new_valid) begin
      // This is a fresh request, or a trap that preempts the current
      // redirect. Any older captured redirect is dropped, because the new one
      // is either issued now or overwrites the capture registers.
      flush_c = 1'b1;
      if (!fetch_stall) begin
        sel_c = new_kind;
        pc_c  = new_target;
        if (HAS_FLUSH_TAIL) begin
          state_d = ST_FLUSHING;
          cnt_d   = FLUSH_RELOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        kind_d   = new_kind;
        target_d = new_target;
        state_d  = ST_PENDING;
      end
    end else begin
      unique case (state_q)
        ST_PENDING: begin
          flush_c = 1'b1;
          if (!fetch_stall) begin
            sel_c = kind_q;
            pc_c  = target_q;
            if (HAS_FLUSH_TAIL) begin
              state_d = ST_FLUSHING;
              cnt_d   = FLUSH_RELOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_FLUSHING: begin
          flush_c = 1'b1;
          // This cycle is the last flush cycle when cnt is 1. Treat 0 the
          // same way so that the FSM always leaves FLUSHING.
          if (cnt_q <= FCNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - FCNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= SEL_PC4;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are held at zero for the whole time reset is high. The state may
  // be anything until the first reset edge.
  always_comb begin
    if (rst) begin
      pc_mux_ctrl = 2'b00;
      redirect_pc = '0;
      flush       = 1'b0;
      busy        = 1'b0;
    end else begin
      pc_mux_ctrl = sel_c;
      redirect_pc = pc_c;
      flush       = flush_c;
      busy        = (state_q != ST_IDLE);
    end
  end

  // Count one per cycle in which the PC mux is actually redirected.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if ((pc_mux_ctrl != 2'b00) && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign redirect_count = count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [31:0] branch_target;
  logic        jal_en;
  logic        jalr_en;
  logic [31:0] jump_target;
  logic        trap_en;
  logic [31:0] trap_vector;
  logic        fetch_stall;

  logic [1:0]  pc_mux_ctrl,  pc_mux_ctrl2,  pc_mux_ctrl3;
  logic [31:0] redirect_pc,  redirect_pc2,  redirect_pc3;
  logic        flush,        flush2,        flush3;
  logic        busy,         busy2,         busy3;
  logic [15:0] redirect_count;
  logic [1:0]  redirect_count2;
  logic [15:0] redirect_count3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Main instance: FLUSH_CYCLES=2, CNT_W=16
  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .branch(branch), .branch_target(branch_target),
    .jal_en(jal_en), .jalr_en(jalr_en), .jump_target(jump_target),
    .trap_en(trap_en), .trap_vector(trap_vector), .fetch_stall(fetch_stall),
    .pc_mux_ctrl(pc_mux_ctrl), .redirect_pc(redirect_pc), .flush(flush),
    .busy(busy), .redirect_count(redirect_count)
  );

  // Narrow counter instance, used to check saturation
  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .branch(branch), .branch_target(branch_target),
    .jal_en(jal_en), .jalr_en(jalr_en), .jump_target(jump_target),
    .trap_en(trap_en), .trap_vector(trap_vector), .fetch_stall(fetch_stall),
    .pc_mux_ctrl(pc_mux_ctrl2), .redirect_pc(redirect_pc2), .flush(flush2),
    .busy(busy2), .redirect_count(redirect_count2)
  );

  // Single-cycle flush instance
  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1), .CNT_W(16)) dut_fc1 (
    .clk(clk), .rst(rst), .branch(branch), .branch_target(branch_target),
    .jal_en(jal_en), .jalr_en(jalr_en), .jump_target(jump_target),
    .trap_en(trap_en), .trap_vector(trap_vector), .fetch_stall(fetch_stall),
    .pc_mux_ctrl(pc_mux_ctrl3), .redirect_pc(redirect_pc3), .flush(flush3),
    .busy(busy3), .redirect_count(redirect_count3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1ns after the next rising edge, where the inputs for the next
  // cycle are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    branch = 0; branch_target = 0; jal_en = 0; jalr_en = 0; jump_target = 0;
    trap_en = 0; trap_vector = 0; fetch_stall = 0;
  endtask

  // Check the main outputs at the falling edge of the current cycle.
  task automatic expect_out(input string tag, input logic [1:0] mux, input logic [31:0] pc,
                            input logic fl, input logic bz);
    @(negedge clk);
    check({tag, ".mux"},   {30'd0, pc_mux_ctrl}, {30'd0, mux});
    check({tag, ".pc"},    redirect_pc, pc);
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
    check({tag, ".busy"},  {31'd0, busy}, {31'd0, bz});
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    // ---- reset: outputs forced low even with a request present ----
    $display("txn: reset");
    branch = 1; branch_target = 32'h100;
    expect_out("rst_force", 2'b00, 32'h0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    rst = 0;
    expect_out("post_rst", 2'b00, 32'h0, 1'b0, 1'b0);
    check("post_rst.count", {16'd0, redirect_count}, 32'd0);
    tick();

    // ---- branch, no stall ----
    $display("txn: branch 0x100 no stall");
    branch = 1; branch_target = 32'h100;
    expect_out("br.c0", 2'b01, 32'h100, 1'b1, 1'b0);
    tick();
    branch = 0;
    expect_out("br.c1", 2'b00, 32'h0, 1'b1, 1'b1);
    check("br.c1.fc1_flush", {31'd0, flush3}, 32'd0);
    check("br.c1.fc1_busy",  {31'd0, busy3},  32'd0);
    tick();
    expect_out("br.c2", 2'b00, 32'h0, 1'b0, 1'b0);
    check("br.c2.count", {16'd0, redirect_count}, 32'd1);
    tick();

    // ---- JAL under a 3-cycle stall ----
    $display("txn: jal 0x2000 stalled 3 cycles");
    jal_en = 1; jump_target = 32'h2000; fetch_stall = 1;
    expect_out("jal.s0", 2'b00, 32'h0, 1'b1, 1'b0);
    tick();
    jal_en = 0; jump_target = 32'hDEAD;  // must not replace the captured target
    expect_out("jal.s1", 2'b00, 32'h0, 1'b1, 1'b1);
    tick();
    jalr_en = 1;                          // wrong path, ignored
    expect_out("jal.s2", 2'b00, 32'h0, 1'b1, 1'b1);
    tick();
    jalr_en = 0; fetch_stall = 0;
    expect_out("jal.issue", 2'b10, 32'h2000, 1'b1, 1'b1);
    tick();
    jump_target = 0;
    expect_out("jal.tail", 2'b00, 32'h0, 1'b1, 1'b1);
    tick();
    expect_out("jal.done", 2'b00, 32'h0, 1'b0, 1'b0);
    check("jal.count", {16'd0, redirect_count}, 32'd2);
    tick();

    // ---- trap beats branch; a branch in FLUSHING is ignored ----
    $display("txn: trap 0x80 with branch");
    branch = 1; branch_target = 32'h300; trap_en = 1; trap_vector = 32'h80;
    expect_out("trp.c0", 2'b11, 32'h80, 1'b1, 1'b0);
    tick();
    trap_en = 0;
    expect_out("trp.c1", 2'b00, 32'h0, 1'b1, 1'b1);
    tick();
    branch = 0;
    expect_out("trp.c2", 2'b00, 32'h0, 1'b0, 1'b0);
    check("trp.count", {16'd0, redirect_count}, 32'd3);
    tick();

    // ---- a trap during FLUSHING preempts and restarts the flush ----
    $display("txn: branch 0x400 then trap 0x90 in flushing");
    branch = 1; branch_target = 32'h400;
    expect_out("pre.c0", 2'b01, 32'h400, 1'b1, 1'b0);
    tick();
    branch = 0; trap_en = 1; trap_vector = 32'h90;
    expect_out("pre.c1", 2'b11, 32'h90, 1'b1, 1'b1);
    tick();
    trap_en = 0;
    expect_out("pre.c2", 2'b00, 32'h0, 1'b1, 1'b1);
    tick();
    expect_out("pre.c3", 2'b00, 32'h0, 1'b0, 1'b0);
    check("pre.count", {16'd0, redirect_count}, 32'd5);
    tick();

    // ---- a newer trap overwrites a pending redirect ----
    $display("txn: stalled branch overwritten by traps 0xA0, 0xB0");
    branch = 1; branch_target = 32'h500; fetch_stall = 1;
    expect_out("ovw.c0", 2'b00, 32'h0, 1'b1, 1'b0);
    tick();
    branch = 0; trap_en = 1; trap_vector = 32'hA0;
    expect_out("ovw.c1", 2'b00, 32'h0, 1'b1, 1'b1);
    tick();
    trap_vector = 32'hB0;
    expect_out("ovw.c2", 2'b00, 32'h0, 1'b1, 1'b1);
    tick();
    trap_en = 0; trap_vector = 0; fetch_stall = 0;
    expect_out("ovw.issue", 2'b11, 32'hB0, 1'b1, 1'b1);
    tick();
    expect_out("ovw.tail", 2'b00, 32'h0, 1'b1, 1'b1);
    tick();
    expect_out("ovw.done", 2'b00, 32'h0, 1'b0, 1'b0);
    check("ovw.count", {16'd0, redirect_count}, 32'd6);
    check("ovw.sat_count", {30'd0, redirect_count2}, 32'd3);
    tick();

    // ---- reset while PENDING ----
    $display("txn: reset during pending jal");
    jal_en = 1; jump_target = 32'h600; fetch_stall = 1;
    expect_out("rp.c0", 2'b00, 32'h0, 1'b1, 1'b0);
    tick();
    jal_en = 0; rst = 1;
    expect_out("rp.rst", 2'b00, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 0;
    expect_out("rp.after", 2'b00, 32'h0, 1'b0, 1'b0);
    check("rp.count", {16'd0, redirect_count}, 32'd0);
    tick();
    fetch_stall = 0;
    expect_out("rp.unstall", 2'b00, 32'h0, 1'b0, 1'b0);
    tick();

    // ---- counter saturation: branch held for 10 cycles gives 5 issues ----
    $display("txn: 5 back-to-back branches");
    branch = 1; branch_target = 32'h700;
    for (int i = 0; i < 10; i++) tick();
    branch = 0;
    @(negedge clk);
    check("sat.count16", {16'd0, redirect_count}, 32'd5);
    check("sat.count2",  {30'd0, redirect_count2}, 32'd3);
    check("sat.fc1_count", {16'd0, redirect_count3}, 32'd10);
    check("sat.flush", {31'd0, flush}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
